// File: rtl/odd_parity_serial_tx.sv
// Nibble-to-serial transmitter: start bit, 4 data bits LSB first, odd parity bit, stop bit.
// Each serial bit is held on tx for CLKS_PER_BIT clock cycles.

module odd_parity_generator (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic e
);

   assign e = ~(a ^ b ^ c ^ d);

endmodule

module odd_parity_serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx,
   output logic       busy,
   output logic       parity_out
);

   // Keep the cycle counter at least one bit wide so CLKS_PER_BIT=1 still elaborates.
   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StParity = 3'd3;
   localparam logic [2:0] StStop   = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      bit_q, bit_d;
   logic [3:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic            tx_q, tx_d;

   logic gen_parity;
   logic bit_end;
   logic accept;

   odd_parity_generator u_parity (
      .a (data_in[3]),
      .b (data_in[2]),
      .c (data_in[1]),
      .d (data_in[0]),
      .e (gen_parity)
   );

   assign bit_end = (cnt_q == CntMax);
   assign accept  = data_valid && (state_q == StIdle);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            bit_d = '0;
            if (accept) begin
               shift_d  = data_in;
               parity_d = gen_parity;
               state_d  = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 2'd3) begin
                  bit_d   = '0;
                  state_d = StParity;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StParity: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StStop;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // tx is registered from the next-state values so the line changes with the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         StIdle:   tx_d = 1'b1;
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = parity_d;
         StStop:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

   assign data_ready = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign tx         = tx_q;
   assign parity_out = parity_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Randomized self-checking bench for odd_parity_serial_tx against a frame-level reference model.

module tb_odd_parity_serial_tx;

   localparam int C = 4;

   logic       clk;
   logic       rst;
   logic [3:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       tx;
   logic       busy;
   logic       parity_out;

   int n_cmp = 0;
   int n_bad = 0;

   odd_parity_serial_tx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .tx         (tx),
      .busy       (busy),
      .parity_out (parity_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // Reference: frame index 0 = start bit, 1..4 = data LSB first, 5 = parity, 6 = stop.
   function automatic logic [6:0] model_frame(input logic [3:0] n);
      logic par;
      par = (($countones(n) % 2) == 0);
      return {1'b1, par, n, 1'b0};
   endfunction

   function automatic logic model_parity(input logic [3:0] n);
      return (($countones(n) % 2) == 0);
   endfunction

   // Waits for idle, then presents the nibble for exactly one accept edge; returns #1 after it.
   task automatic do_accept(input logic [3:0] n);
      int w;
      w = 0;
      while (!data_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!data_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: data_ready=%b required 1", data_ready);
      end
      data_in    = n;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   // Observes the line after an accept edge until busy drops; performs no comparisons itself.
   task automatic capture_frame(output logic [6:0] bits, output logic stable, output int busy_cnt);
      bits     = '0;
      stable   = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) break;
         busy_cnt++;
         if (i < 7 * C) begin
            if (i % C == 0) bits[i / C] = tx;
            else if (tx !== bits[i / C]) stable = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      data_valid = 1'b0;
      data_in    = 4'b0000;
      @(negedge clk);
      data_in    = 4'b1010;
      data_valid = 1'b1;
      repeat (2) @(negedge clk);
      data_valid = 1'b0;
      n_cmp++;
      if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if (data_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready: got %b want 1", data_ready);
      end
      n_cmp++;
      if (parity_out !== 1'b0) begin
         n_bad++; $display("FAIL reset_parity: got %b want 0", parity_out);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_bad++; $display("FAIL reset_no_accept: busy=%b tx=%b want busy=0 tx=1", busy, tx);
      end
   endtask

   task automatic test_zero_frame();
      logic [6:0] bits;
      logic       stable;
      int         bc;
      do_accept(4'b0000);
      n_cmp++;
      if (parity_out !== 1'b1) begin
         n_bad++; $display("FAIL zero_parity: got %b want 1", parity_out);
      end
      capture_frame(bits, stable, bc);
      n_cmp++;
      if (bits !== model_frame(4'b0000)) begin
         n_bad++; $display("FAIL zero_frame: got %b want %b", bits, model_frame(4'b0000));
      end
      n_cmp++;
      if (stable !== 1'b1) begin n_bad++; $display("FAIL zero_hold: bit not held %0d cycles", C); end
      n_cmp++;
      if (bc !== 7 * C) begin n_bad++; $display("FAIL zero_busy_len: got %0d want %0d", bc, 7 * C); end
      n_cmp++;
      if (data_ready !== 1'b1) begin
         n_bad++; $display("FAIL zero_ready_after: got %b want 1", data_ready);
      end
   endtask

   task automatic test_mid_change();
      logic [6:0] bits;
      logic       stable;
      int         bc;
      do_accept(4'b0111);
      data_in = 4'b1111;
      n_cmp++;
      if (parity_out !== 1'b0) begin
         n_bad++; $display("FAIL midchg_parity: got %b want 0", parity_out);
      end
      capture_frame(bits, stable, bc);
      n_cmp++;
      if (bits !== model_frame(4'b0111) || stable !== 1'b1) begin
         n_bad++;
         $display("FAIL midchg_frame: got %b stable=%b want %b", bits, stable, model_frame(4'b0111));
      end
   endtask

   task automatic test_sweep();
      logic [6:0] bits;
      logic       stable;
      int         bc;
      for (int n = 0; n < 16; n++) begin
         do_accept(4'(n));
         n_cmp++;
         if (parity_out !== model_parity(4'(n))) begin
            n_bad++;
            $display("FAIL sweep_parity n=%0d: got %b want %b", n, parity_out, model_parity(4'(n)));
         end
         n_cmp++;
         if ((($countones(4'(n)) + int'(parity_out)) % 2) != 1) begin
            n_bad++; $display("FAIL sweep_odd n=%0d: parity_out=%b gives even total", n, parity_out);
         end
         capture_frame(bits, stable, bc);
         n_cmp++;
         if (bits[4:1] !== 4'(n)) begin
            n_bad++; $display("FAIL sweep_rebuild: got %b want %b", bits[4:1], 4'(n));
         end
         n_cmp++;
         if (bits !== model_frame(4'(n)) || stable !== 1'b1 || bc != 7 * C) begin
            n_bad++;
            $display("FAIL sweep_frame n=%0d: got %b stable=%b busy=%0d want %b busy=%0d",
                     n, bits, stable, bc, model_frame(4'(n)), 7 * C);
         end
      end
   endtask

   task automatic test_random_busy_noise();
      logic [6:0] bits;
      logic       stable;
      int         bc;
      logic [3:0] n;
      for (int k = 0; k < 10; k++) begin
         n = 4'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_accept(n);
         fork
            capture_frame(bits, stable, bc);
            begin
               repeat (7 * C - 3) begin
                  @(posedge clk);
                  #1;
                  data_valid = 1'($urandom);
                  data_in    = 4'($urandom);
               end
               data_valid = 1'b0;
            end
         join
         n_cmp++;
         if (bits !== model_frame(n) || stable !== 1'b1 || bc != 7 * C) begin
            n_bad++;
            $display("FAIL rand_frame n=%b: got %b stable=%b busy=%0d want %b busy=%0d",
                     n, bits, stable, bc, model_frame(n), 7 * C);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] bits;
      logic       stable;
      int         bc;
      int         sp;
      int         w;
      w = 0;
      while (!data_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      data_in    = 4'b1011;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_in = 4'b0001;
      n_cmp++;
      if (parity_out !== model_parity(4'b1011)) begin
         n_bad++; $display("FAIL b2b_parity1: got %b want %b", parity_out, model_parity(4'b1011));
      end
      sp = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (data_ready) begin
            sp = k + 1;
            break;
         end
      end
      n_cmp++;
      if (sp != 7 * C + 1) begin
         n_bad++; $display("FAIL b2b_spacing: got %0d cycles want %0d", sp, 7 * C + 1);
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      n_cmp++;
      if (parity_out !== model_parity(4'b0001)) begin
         n_bad++; $display("FAIL b2b_parity2: got %b want %b", parity_out, model_parity(4'b0001));
      end
      capture_frame(bits, stable, bc);
      n_cmp++;
      if (bits !== model_frame(4'b0001) || bc != 7 * C) begin
         n_bad++;
         $display("FAIL b2b_frame2: got %b busy=%0d want %b", bits, bc, model_frame(4'b0001));
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [6:0] bits;
      logic       stable;
      int         bc;
      do_accept(4'b0101);
      repeat (2 * C + 1) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_tx: got %b want 0", tx); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_async: tx=%b busy=%b ready=%b want 1 0 1", tx, busy, data_ready);
      end
      n_cmp++;
      if (parity_out !== 1'b0) begin
         n_bad++; $display("FAIL midrst_parity: got %b want 0", parity_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_accept(4'b1000);
      n_cmp++;
      if (parity_out !== 1'b0) begin
         n_bad++; $display("FAIL postrst_parity: got %b want 0", parity_out);
      end
      capture_frame(bits, stable, bc);
      n_cmp++;
      if (bits !== model_frame(4'b1000) || stable !== 1'b1 || bc != 7 * C) begin
         n_bad++;
         $display("FAIL postrst_frame: got %b busy=%0d want %b", bits, bc, model_frame(4'b1000));
      end
   endtask

   initial begin
      test_reset();
      test_zero_frame();
      test_mid_change();
      test_sweep();
      test_random_busy_noise();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
